// File: rtl/axi_ad7616_up_regs.sv
// Register bank for the AD7616 control space: up_* bus writes and reads, device
// control outputs, conversion-start pulse generator and device register-write launch.
module axi_ad7616_up_regs #(
  parameter logic [31:0] ID      = 32'd0,
  parameter logic [31:0] VERSION = 32'h00001002
) (
  input  logic        up_clk,
  input  logic        up_rst,
  input  logic        up_wreq,
  input  logic [13:0] up_waddr,
  input  logic [31:0] up_wdata,
  output logic        up_wack,
  input  logic        up_rreq,
  input  logic [13:0] up_raddr,
  output logic [31:0] up_rdata,
  output logic        up_rack,
  output logic        dev_resetn,
  output logic        cnvst_en,
  output logic        cnvst,
  output logic [4:0]  burst_length,
  output logic        wr_req,
  output logic [15:0] wr_data,
  input  logic        wr_ack,
  input  logic        rd_valid,
  input  logic [15:0] rd_data
);

  localparam logic [13:0] ADDR_VERSION    = 14'h000;
  localparam logic [13:0] ADDR_ID         = 14'h001;
  localparam logic [13:0] ADDR_SCRATCH    = 14'h002;
  localparam logic [13:0] ADDR_CNTRL      = 14'h010;
  localparam logic [13:0] ADDR_CONV_RATE  = 14'h011;
  localparam logic [13:0] ADDR_BURST_LEN  = 14'h012;
  localparam logic [13:0] ADDR_READ_DATA  = 14'h013;
  localparam logic [13:0] ADDR_WRITE_DATA = 14'h014;

  typedef enum logic {
    WR_IDLE,
    WR_PEND
  } wr_state_t;

  wr_state_t   state_q, state_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        wack_q, rack_q;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] scratch_q;
  logic [1:0]  cntrl_q;
  logic [31:0] conv_rate_q;
  logic [4:0]  burst_q;
  logic [15:0] read_data_q;
  logic [31:0] cnt_q, cnt_d;
  logic        cnvst_q, cnvst_d;

  logic wr_scratch, wr_cntrl, wr_conv_rate, wr_burst, wr_wdata;

  assign wr_scratch   = up_wreq && (up_waddr == ADDR_SCRATCH);
  assign wr_cntrl     = up_wreq && (up_waddr == ADDR_CNTRL);
  assign wr_conv_rate = up_wreq && (up_waddr == ADDR_CONV_RATE);
  assign wr_burst     = up_wreq && (up_waddr == ADDR_BURST_LEN);
  assign wr_wdata     = up_wreq && (up_waddr == ADDR_WRITE_DATA);

  // Read mux samples the pre-update register values, so a same-cycle write or
  // rd_valid capture is not visible until the following read.
  always_comb begin
    rdata_d = '0;
    if (up_rreq) begin
      case (up_raddr)
        ADDR_VERSION:   rdata_d = VERSION;
        ADDR_ID:        rdata_d = ID;
        ADDR_SCRATCH:   rdata_d = scratch_q;
        ADDR_CNTRL:     rdata_d = {30'd0, cntrl_q};
        ADDR_CONV_RATE: rdata_d = conv_rate_q;
        ADDR_BURST_LEN: rdata_d = {27'd0, burst_q};
        ADDR_READ_DATA: rdata_d = {16'd0, read_data_q};
        default:        rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_data_d = wr_data_q;
    case (state_q)
      WR_IDLE: begin
        if (wr_wdata) begin
          wr_data_d = up_wdata[15:0];
          state_d   = WR_PEND;
        end
      end
      WR_PEND: begin
        if (wr_ack) begin
          state_d = WR_IDLE;
        end
      end
      default: state_d = WR_IDLE;
    endcase
  end

  // Pulse is registered off the terminal count, so the first one appears
  // conv_rate cycles after the edge that enabled or reconfigured the generator.
  always_comb begin
    cnt_d   = '0;
    cnvst_d = 1'b0;
    if (!(wr_cntrl || wr_conv_rate) && (cntrl_q == 2'b11) && (conv_rate_q != '0)) begin
      if (cnt_q == (conv_rate_q - 32'd1)) begin
        cnvst_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge up_clk or posedge up_rst) begin
    if (up_rst) begin
      wack_q      <= 1'b0;
      rack_q      <= 1'b0;
      rdata_q     <= '0;
      scratch_q   <= '0;
      cntrl_q     <= '0;
      conv_rate_q <= '0;
      burst_q     <= '0;
      read_data_q <= '0;
      state_q     <= WR_IDLE;
      wr_data_q   <= '0;
      cnt_q       <= '0;
      cnvst_q     <= 1'b0;
    end else begin
      wack_q  <= up_wreq;
      rack_q  <= up_rreq;
      rdata_q <= rdata_d;
      if (wr_scratch)   scratch_q   <= up_wdata;
      if (wr_cntrl)     cntrl_q     <= up_wdata[1:0];
      if (wr_conv_rate) conv_rate_q <= up_wdata;
      if (wr_burst)     burst_q     <= up_wdata[4:0];
      if (rd_valid)     read_data_q <= rd_data;
      state_q   <= state_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
      cnvst_q   <= cnvst_d;
    end
  end

  assign up_wack      = wack_q;
  assign up_rack      = rack_q;
  assign up_rdata     = rdata_q;
  assign dev_resetn   = cntrl_q[0];
  assign cnvst_en     = cntrl_q[1];
  assign cnvst        = cnvst_q;
  assign burst_length = burst_q;
  assign wr_req       = (state_q == WR_PEND);
  assign wr_data      = wr_data_q;

endmodule

// File: tb/tb_axi_ad7616_up_regs.sv
// Directed plus randomized bench for axi_ad7616_up_regs against a behavioural
// register-map model; conversion pulses are predicted from elapsed cycle counts.
module tb_axi_ad7616_up_regs;

  logic        up_clk = 1'b0;
  logic        up_rst = 1'b1;
  logic        up_wreq = 1'b0;
  logic [13:0] up_waddr = '0;
  logic [31:0] up_wdata = '0;
  logic        up_wack;
  logic        up_rreq = 1'b0;
  logic [13:0] up_raddr = '0;
  logic [31:0] up_rdata;
  logic        up_rack;
  logic        dev_resetn;
  logic        cnvst_en;
  logic        cnvst;
  logic [4:0]  burst_length;
  logic        wr_req;
  logic [15:0] wr_data;
  logic        wr_ack = 1'b0;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_data = '0;

  axi_ad7616_up_regs #(.ID(32'd0), .VERSION(32'h00001002)) dut (
    .up_clk(up_clk), .up_rst(up_rst),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack),
    .dev_resetn(dev_resetn), .cnvst_en(cnvst_en), .cnvst(cnvst),
    .burst_length(burst_length), .wr_req(wr_req), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 up_clk = ~up_clk;

  int unsigned cyc = 0;
  always @(posedge up_clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model of the software-visible state
  logic [31:0] m_scratch, m_cntrl, m_rate, m_burst, m_rdreg;
  logic [15:0] m_wrdata;
  logic        m_pend;
  int unsigned t0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_scratch = '0; m_cntrl = '0; m_rate = '0; m_burst = '0; m_rdreg = '0;
    m_wrdata = '0; m_pend = 1'b0; t0 = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [13:0] a);
    case (a)
      14'h000: return 32'h00001002;
      14'h001: return 32'd0;
      14'h002: return m_scratch;
      14'h010: return m_cntrl;
      14'h011: return m_rate;
      14'h012: return m_burst;
      14'h013: return m_rdreg;
      default: return 32'd0;
    endcase
  endfunction

  // Pulse expected whenever a whole number (>0) of periods has elapsed since config
  function automatic logic m_cnvst();
    int unsigned d;
    if (m_cntrl != 32'd3 || m_rate == 0) return 1'b0;
    d = cyc - t0;
    return (d > 0) && (d % m_rate == 0);
  endfunction

  task automatic check_outs(input string tag);
    check({tag, ".dev_resetn"}, {31'd0, dev_resetn}, {31'd0, m_cntrl[0]});
    check({tag, ".cnvst_en"}, {31'd0, cnvst_en}, {31'd0, m_cntrl[1]});
    check({tag, ".cnvst"}, {31'd0, cnvst}, {31'd0, m_cnvst()});
    check({tag, ".burst"}, {27'd0, burst_length}, m_burst);
    check({tag, ".wr_req"}, {31'd0, wr_req}, {31'd0, m_pend});
    check({tag, ".wr_data"}, {16'd0, wr_data}, {16'd0, m_wrdata});
  endtask

  task automatic model_write(input logic [13:0] a, input logic [31:0] d);
    case (a)
      14'h002: m_scratch = d;
      14'h010: begin m_cntrl = d & 32'h3; t0 = cyc; end
      14'h011: begin m_rate = d; t0 = cyc; end
      14'h012: m_burst = d & 32'h1F;
      14'h014: if (!m_pend) begin m_wrdata = d[15:0]; m_pend = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic do_write(input logic [13:0] a, input logic [31:0] d);
    @(negedge up_clk);
    up_wreq = 1'b1; up_waddr = a; up_wdata = d;
    @(negedge up_clk);
    up_wreq = 1'b0;
    model_write(a, d);
    check("wack", {31'd0, up_wack}, 32'd1);
    check_outs("after_write");
  endtask

  task automatic do_read(input logic [13:0] a, input string tag);
    logic [31:0] exp;
    @(negedge up_clk);
    up_rreq = 1'b1; up_raddr = a;
    exp = m_read(a);
    @(negedge up_clk);
    up_rreq = 1'b0;
    check({tag, ".rack"}, {31'd0, up_rack}, 32'd1);
    check({tag, ".rdata"}, up_rdata, exp);
  endtask

  task automatic tick_check(input int unsigned n, input string tag);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge up_clk);
      check_outs(tag);
    end
  endtask

  task automatic ack_device();
    wr_ack = 1'b1;
    @(negedge up_clk);
    wr_ack = 1'b0;
    m_pend = 1'b0;
    check_outs("after_ack");
  endtask

  initial begin
    logic [31:0] r;
    logic [15:0] v;
    logic [31:0] exp;
    int unsigned k;

    model_reset();
    repeat (3) @(negedge up_clk);
    check_outs("reset");
    check("reset.wack", {31'd0, up_wack}, 32'd0);
    check("reset.rack", {31'd0, up_rack}, 32'd0);
    check("reset.rdata", up_rdata, 32'd0);
    up_rst = 1'b0;

    do_read(14'h000, "rd_version");
    do_read(14'h001, "rd_id");
    do_read(14'h010, "rd_cntrl_rst");
    do_read(14'h013, "rd_rdreg_rst");
    do_read(14'h011, "rd_rate_rst");
    @(negedge up_clk);
    check("idle.rack", {31'd0, up_rack}, 32'd0);
    check("idle.rdata", up_rdata, 32'd0);

    do_write(14'h002, 32'hDEADBEEF);
    do_read(14'h002, "rd_scratch");
    for (int i = 0; i < 4; i++) begin
      do_write(14'h002, $urandom);
      do_read(14'h002, "rd_scratch_rand");
    end

    do_write(14'h012, 32'hFFFFFFFF);
    do_read(14'h012, "rd_burst_max");
    for (int i = 0; i < 3; i++) begin
      do_write(14'h012, $urandom);
      do_read(14'h012, "rd_burst_rand");
    end

    do_read(14'h014, "rd_wdata_wo");
    do_read(14'h3FFF, "rd_unmapped");
    do_write(14'h003, 32'h12345678);
    do_read(14'h003, "rd_unmapped_wr");
    do_write(14'h000, 32'h0BADF00D);
    do_read(14'h000, "rd_version_ro");

    // Conversion-start generator
    do_write(14'h011, 32'd10);
    do_write(14'h010, 32'd3);
    tick_check(45, "cnv10");
    r = $urandom_range(2, 6);
    do_write(14'h011, r);
    tick_check(3 * r + 2, "cnv_rand");
    do_write(14'h011, 32'd1);
    tick_check(6, "cnv1");
    do_write(14'h010, 32'd1);
    tick_check(15, "cnv_off");
    do_write(14'h011, 32'd4);
    do_write(14'h010, 32'd2);
    tick_check(10, "cnv_devrst");
    do_read(14'h010, "rd_cntrl_2");
    do_write(14'h011, 32'd0);
    do_write(14'h010, 32'd3);
    tick_check(6, "cnv_rate0");
    do_write(14'h010, 32'd0);

    // Device register-write launch
    do_write(14'h014, 32'h00001234);
    tick_check(5, "wr_pend");
    do_write(14'h014, 32'h00005678);
    tick_check(1, "wr_drop");
    ack_device();
    tick_check(2, "wr_idle");
    for (int i = 0; i < 3; i++) begin
      do_write(14'h014, $urandom);
      k = $urandom_range(0, 3);
      tick_check(k, "wr_rand_pend");
      ack_device();
    end

    // Device read-data capture racing a software read
    for (int i = 0; i < 3; i++) begin
      v = (i == 0) ? 16'hA5A5 : 16'($urandom_range(0, 65535));
      @(negedge up_clk);
      rd_valid = 1'b1; rd_data = v; up_rreq = 1'b1; up_raddr = 14'h013;
      exp = m_read(14'h013);
      @(negedge up_clk);
      rd_valid = 1'b0; up_rreq = 1'b0;
      m_rdreg = {16'd0, v};
      check("rdreg_race.rdata", up_rdata, exp);
      do_read(14'h013, "rdreg_new");
    end

    // Simultaneous write and read of the same register
    r = $urandom;
    @(negedge up_clk);
    up_wreq = 1'b1; up_waddr = 14'h002; up_wdata = r;
    up_rreq = 1'b1; up_raddr = 14'h002;
    exp = m_read(14'h002);
    @(negedge up_clk);
    up_wreq = 1'b0; up_rreq = 1'b0;
    model_write(14'h002, r);
    check("wr_rd.wack", {31'd0, up_wack}, 32'd1);
    check("wr_rd.rdata", up_rdata, exp);
    do_read(14'h002, "wr_rd_after");

    // Asynchronous reset mid-operation
    do_write(14'h011, 32'd1);
    do_write(14'h010, 32'd3);
    do_write(14'h014, 32'h0000BEEF);
    tick_check(2, "pre_rst");
    @(negedge up_clk);
    #2 up_rst = 1'b1;
    #1 model_reset();
    check_outs("async_rst");
    @(negedge up_clk);
    up_rst = 1'b0;
    do_read(14'h002, "post_rst_scratch");
    do_read(14'h010, "post_rst_cntrl");
    do_read(14'h011, "post_rst_rate");
    do_read(14'h012, "post_rst_burst");
    do_read(14'h000, "post_rst_version");
    tick_check(3, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
